datamover_cmd_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI DataMover S2MM (or MM2S) command channel between NUM_REQ requesters.
Each grant is packed into the 72-bit DataMover command word, tagged with the requester index, and tracked as pending.
Returned status beats are decoded by tag and routed back to the owning requester as a done/error pulse.
Sits between local transfer engines (test generators, DMA clients) and the DataMover command/status ports.

---
 rtl/datamover_cmd_arbiter_if.sv | 39 +++
 rtl/datamover_cmd_arbiter.sv | 113 +++++++++++
 tb/tb_datamover_cmd_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/datamover_cmd_arbiter_if.sv
// Requester, DataMover command and status signals of the command arbiter.
// The arbiter connects through the slave modport; the requester and
// DataMover side drives through the master modport.
interface datamover_cmd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int BTT_WIDTH  = 23
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [NUM_REQ*BTT_WIDTH-1:0]  i_req_btt;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [71:0]                   o_cmd_tdata;
  logic                          o_cmd_tvalid;
  logic                          i_cmd_tready;
  logic [7:0]                    i_sts_tdata;
  logic                          i_sts_tvalid;
  logic                          i_sts_tlast;
  logic                          o_sts_tready;
  logic [NUM_REQ-1:0]            o_done;
  logic [NUM_REQ-1:0]            o_done_err;
  logic                          o_sts_unexpected;
  logic [NUM_REQ-1:0]            o_pending;
  logic                          o_busy;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_btt, i_cmd_tready,
           i_sts_tdata, i_sts_tvalid, i_sts_tlast,
    output o_req_ready, o_cmd_tdata, o_cmd_tvalid, o_sts_tready,
           o_done, o_done_err, o_sts_unexpected, o_pending, o_busy
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_btt, i_cmd_tready,
           i_sts_tdata, i_sts_tvalid, i_sts_tlast,
    input  o_req_ready, o_cmd_tdata, o_cmd_tvalid, o_sts_tready,
           o_done, o_done_err, o_sts_unexpected, o_pending, o_busy
  );
endinterface

// File: rtl/datamover_cmd_arbiter.sv
// Round-robin arbiter sharing one DataMover command channel between
// NUM_REQ requesters. Each issued command is tagged with its requester
// index and tracked as pending until the matching status beat returns.
module datamover_cmd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int BTT_WIDTH  = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  datamover_cmd_arbiter_if.slave bus
);

  typedef enum logic {ARB, ISSUE} state_t;

  state_t             state, state_nxt;
  logic [3:0]         ptr, sel, cmd_tag, sts_tag;
  logic [31:0]        cmd_addr;
  logic [22:0]        cmd_btt;
  logic [NUM_REQ-1:0] pending, elig, set_mask, clr_mask, done_q, err_q;
  logic               any_elig, accept, sts_beat, sts_hit, sts_err, unexp_q;
  int                 j;

  assign elig     = bus.i_req_valid & ~pending;
  assign accept   = (state == ISSUE) && bus.i_cmd_tready;
  assign sts_beat = bus.i_sts_tvalid && bus.i_sts_tlast;
  assign sts_tag  = bus.i_sts_tdata[3:0];
  assign sts_err  = (|bus.i_sts_tdata[6:4]) || !bus.i_sts_tdata[7];

  // Per-requester accept and status-match decode; tags >= NUM_REQ match nothing.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    assign set_mask[k] = accept && (cmd_tag == 4'(k));
    assign clr_mask[k] = sts_beat && (sts_tag == 4'(k)) && pending[k];
  end

  assign sts_hit = |clr_mask;

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    j        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_elig && elig[j]) begin
        any_elig = 1'b1;
        sel      = 4'(j);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  // Next state: grant when something is eligible, hold until accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (any_elig) state_nxt = ISSUE;
      ISSUE:   if (bus.i_cmd_tready) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Command capture at grant and pointer advance on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      cmd_tag  <= '0;
      cmd_addr <= '0;
      cmd_btt  <= '0;
    end else begin
      if (state == ARB && any_elig) begin
        cmd_tag  <= sel;
        cmd_addr <= 32'(bus.i_req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH]);
        cmd_btt  <= 23'(bus.i_req_btt[int'(sel)*BTT_WIDTH +: BTT_WIDTH]);
      end
      if (accept)
        ptr <= (int'(cmd_tag) == NUM_REQ - 1) ? 4'd0 : cmd_tag + 4'd1;
    end
  end

  // Pending tracking and registered status reporting; set and clear can coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      done_q  <= '0;
      err_q   <= '0;
      unexp_q <= 1'b0;
    end else begin
      pending <= (pending | set_mask) & ~clr_mask;
      done_q  <= clr_mask;
      err_q   <= clr_mask & {NUM_REQ{sts_err}};
      unexp_q <= sts_beat && !sts_hit;
    end
  end

  // Command word: tag, address, DRR clear, EOF set, DSA zero, INCR, BTT.
  assign bus.o_cmd_tdata      = {4'h0, cmd_tag, cmd_addr, 1'b0, 1'b1, 6'h00, 1'b1, cmd_btt};
  assign bus.o_cmd_tvalid     = (state == ISSUE);
  assign bus.o_req_ready      = set_mask;
  assign bus.o_sts_tready     = 1'b1;
  assign bus.o_done           = done_q;
  assign bus.o_done_err       = err_q;
  assign bus.o_sts_unexpected = unexp_q;
  assign bus.o_pending        = pending;
  assign bus.o_busy           = (state == ISSUE) || (|pending);

endmodule

// File: tb/tb_datamover_cmd_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_datamover_cmd_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  datamover_cmd_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(32), .BTT_WIDTH(23)) bus ();
  datamover_cmd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .BTT_WIDTH(23)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  bit cyc_en = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] pack(input int tag, input logic [31:0] a, input logic [22:0] b);
    return (72'(tag) << 64) | (72'(a) << 32) | 72'h4080_0000 | 72'(b);
  endfunction

  // Behavioural model: one command slot in flight, a pending set, a pointer.
  bit          m_have;
  int          m_tag, m_ptr;
  logic [31:0] m_addr;
  logic [22:0] m_btt;
  logic [N-1:0] m_pend, m_done, m_err, np;
  bit          m_unexp, acc, beat, hit, found;
  int          t, idx;

  initial begin
    m_have = 0; m_tag = 0; m_ptr = 0; m_addr = '0; m_btt = '0;
    m_pend = '0; m_done = '0; m_err = '0; m_unexp = 0;
  end

  always @(negedge clk) begin
    if (cyc_en) begin
      chk("cmd_tvalid", 72'(bus.o_cmd_tvalid), 72'(m_have));
      if (m_have) chk("cmd_tdata", bus.o_cmd_tdata, pack(m_tag, m_addr, m_btt));
      chk("req_ready", 72'(bus.o_req_ready),
          72'((m_have && bus.i_cmd_tready) ? (1 << m_tag) : 0));
      chk("pending", 72'(bus.o_pending), 72'(m_pend));
      chk("busy", 72'(bus.o_busy), 72'(m_have || (m_pend != 0)));
      chk("done", 72'(bus.o_done), 72'(m_done));
      chk("done_err", 72'(bus.o_done_err), 72'(m_err));
      chk("sts_unexpected", 72'(bus.o_sts_unexpected), 72'(m_unexp));
      chk("sts_tready", 72'(bus.o_sts_tready), 72'd1);
    end
    if (rst) begin
      m_have = 0; m_ptr = 0; m_pend = '0; m_done = '0; m_err = '0; m_unexp = 0;
    end else begin
      acc  = m_have && bus.i_cmd_tready;
      beat = bus.i_sts_tvalid && bus.i_sts_tlast;
      t    = int'(bus.i_sts_tdata[3:0]);
      hit  = 0;
      if (beat && t < N) hit = m_pend[t];
      np      = m_pend;
      m_done  = hit ? N'(1 << t) : '0;
      m_err   = (hit && ((|bus.i_sts_tdata[6:4]) || !bus.i_sts_tdata[7])) ? m_done : '0;
      m_unexp = beat && !hit;
      if (hit) np[t] = 1'b0;
      if (acc) begin
        np[m_tag] = 1'b1;
        m_ptr = (m_tag + 1) % N;
        m_have = 0;
      end else if (!m_have) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          idx = (m_ptr + i) % N;
          if (!found && bus.i_req_valid[idx] && !m_pend[idx]) begin
            found = 1; m_have = 1; m_tag = idx;
            m_addr = bus.i_req_addr[idx*32 +: 32];
            m_btt  = bus.i_req_btt[idx*23 +: 23];
          end
        end
      end
      m_pend = np;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    bus.i_req_valid = '0; bus.i_cmd_tready = 1'b0;
    bus.i_sts_tvalid = 1'b0; bus.i_sts_tlast = 1'b0; bus.i_sts_tdata = '0;
    tick(); tick(); rst = 1'b0;
  endtask

  task automatic wait_tvalid(input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.o_cmd_tvalid) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("wait_tvalid_timeout", 72'd0, 72'd1);
  endtask

  task automatic send_sts(input logic [7:0] d);
    tick(); bus.i_sts_tdata = d; bus.i_sts_tvalid = 1'b1; bus.i_sts_tlast = 1'b1;
    @(negedge clk);
    tick(); bus.i_sts_tvalid = 1'b0; bus.i_sts_tlast = 1'b0;
    @(negedge clk);
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  logic [N-1:0] last_rdy;
  int gq[$];
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.i_req_valid = '0; bus.i_req_addr = '0; bus.i_req_btt = '0;
    bus.i_cmd_tready = 1'b0; bus.i_sts_tdata = '0;
    bus.i_sts_tvalid = 1'b0; bus.i_sts_tlast = 1'b0;
    tick(); tick();
    cyc_en = 1'b1;
    rst = 1'b0;

    // Reset state and single request
    @(negedge clk);
    chk("rst_tvalid", 72'(bus.o_cmd_tvalid), 72'd0);
    chk("rst_pending", 72'(bus.o_pending), 72'd0);
    chk("rst_busy", 72'(bus.o_busy), 72'd0);
    chk("rst_sts_tready", 72'(bus.o_sts_tready), 72'd1);
    tick();
    bus.i_req_valid[0] = 1'b1; bus.i_req_addr[0 +: 32] = 32'h1000_0000;
    bus.i_req_btt[0 +: 23] = 23'h100; bus.i_cmd_tready = 1'b1;
    @(negedge clk);
    chk("single_tvalid_n", 72'(bus.o_cmd_tvalid), 72'd0);
    tick(); @(negedge clk);
    chk("single_tvalid_n1", 72'(bus.o_cmd_tvalid), 72'd1);
    chk("single_tdata", bus.o_cmd_tdata, 72'h0_0_10000000_40800100);
    chk("single_ready", 72'(bus.o_req_ready), 72'h1);
    tick(); bus.i_req_valid[0] = 1'b0; @(negedge clk);
    chk("single_pending", 72'(bus.o_pending), 72'h1);
    send_sts(8'h80);
    chk("single_done", 72'(bus.o_done), 72'h1);
    chk("single_err", 72'(bus.o_done_err), 72'h0);
    chk("single_pending_clr", 72'(bus.o_pending), 72'h0);

    // Round-robin with immediate status return
    do_reset();
    for (int k = 0; k < N; k++) begin
      bus.i_req_addr[k*32 +: 32] = 32'(k) << 28;
      bus.i_req_btt[k*23 +: 23] = 23'(k + 1);
    end
    bus.i_req_valid = '1; bus.i_cmd_tready = 1'b1; last_rdy = '0;
    for (int c = 0; c < 80 && gq.size() < 5; c++) begin
      tick();
      bus.i_sts_tvalid = (last_rdy != 0); bus.i_sts_tlast = (last_rdy != 0);
      bus.i_sts_tdata = 8'h80 | 8'(oh_idx(last_rdy) & 15);
      @(negedge clk);
      last_rdy = bus.o_req_ready;
      if (last_rdy != 0) gq.push_back(oh_idx(last_rdy));
    end
    tick(); bus.i_req_valid = '0; bus.i_sts_tvalid = 1'b0; bus.i_sts_tlast = 1'b0;
    chk("rr_count", 72'(gq.size()), 72'd5);
    for (int i = 0; i < 5; i++)
      if (i < gq.size()) chk($sformatf("rr_grant%0d", i), 72'(gq[i]), 72'(rr_exp[i]));

    // Backpressure for 10 cycles
    do_reset();
    bus.i_req_valid[1] = 1'b1; bus.i_req_addr[32 +: 32] = 32'hABCD_0000;
    bus.i_req_btt[23 +: 23] = 23'h7F_FFFF;
    wait_tvalid(10);
    for (int i = 0; i < 10; i++) begin
      chk("bp_tvalid", 72'(bus.o_cmd_tvalid), 72'd1);
      chk("bp_tdata", bus.o_cmd_tdata, 72'h0_1_ABCD0000_40FFFFFF);
      chk("bp_ready", 72'(bus.o_req_ready), 72'h0);
      if (i < 9) begin tick(); @(negedge clk); end
    end
    tick(); bus.i_cmd_tready = 1'b1; @(negedge clk);
    chk("bp_ready_release", 72'(bus.o_req_ready), 72'h2);
    tick(); bus.i_req_valid[1] = 1'b0;

    // One outstanding command per requester
    do_reset();
    bus.i_req_valid[2] = 1'b1; bus.i_cmd_tready = 1'b1;
    wait_tvalid(10);
    chk("oo_ready", 72'(bus.o_req_ready), 72'h4);
    for (int i = 0; i < 6; i++) begin
      tick(); @(negedge clk);
      chk("oo_no_regrant", 72'(bus.o_cmd_tvalid), 72'd0);
    end
    tick(); bus.i_sts_tdata = 8'h82; bus.i_sts_tvalid = 1'b1; bus.i_sts_tlast = 1'b1;
    @(negedge clk);
    chk("oo_s0", 72'(bus.o_cmd_tvalid), 72'd0);
    tick(); bus.i_sts_tvalid = 1'b0; bus.i_sts_tlast = 1'b0; @(negedge clk);
    chk("oo_s1", 72'(bus.o_cmd_tvalid), 72'd0);
    chk("oo_done", 72'(bus.o_done), 72'h4);
    tick(); @(negedge clk);
    chk("oo_s2", 72'(bus.o_cmd_tvalid), 72'd1);
    tick(); bus.i_req_valid[2] = 1'b0;

    // Error status and unexpected status
    do_reset();
    bus.i_req_valid[1] = 1'b1; bus.i_cmd_tready = 1'b1;
    wait_tvalid(10);
    tick(); bus.i_req_valid[1] = 1'b0; @(negedge clk);
    send_sts(8'h31);
    chk("err_done", 72'(bus.o_done), 72'h2);
    chk("err_err", 72'(bus.o_done_err), 72'h2);
    send_sts(8'h83);
    chk("unexp_pulse", 72'(bus.o_sts_unexpected), 72'd1);
    chk("unexp_pending", 72'(bus.o_pending), 72'h0);

    // Reset while a command waits for tready
    do_reset();
    bus.i_req_valid[1] = 1'b1; bus.i_cmd_tready = 1'b1;
    wait_tvalid(10);
    tick(); bus.i_req_valid[1] = 1'b0; bus.i_req_valid[0] = 1'b1; bus.i_cmd_tready = 1'b0;
    wait_tvalid(10);
    chk("ri_pending_before", 72'(bus.o_pending), 72'h2);
    tick(); rst = 1'b1; @(negedge clk);
    tick(); rst = 1'b0; bus.i_req_valid[0] = 1'b0; @(negedge clk);
    chk("ri_tvalid", 72'(bus.o_cmd_tvalid), 72'd0);
    chk("ri_pending", 72'(bus.o_pending), 72'h0);
    send_sts(8'h80);
    chk("ri_unexp0", 72'(bus.o_sts_unexpected), 72'd1);
    send_sts(8'h81);
    chk("ri_unexp1", 72'(bus.o_sts_unexpected), 72'd1);

    // Randomized traffic; requesters hold their request until accepted
    last_rdy = '0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = ($urandom_range(0, 249) == 0);
      for (int k = 0; k < N; k++) begin
        if (last_rdy[k]) begin
          if ($urandom_range(0, 1) == 0) bus.i_req_valid[k] = 1'b0;
        end else if (!bus.i_req_valid[k] && $urandom_range(0, 3) == 0) begin
          bus.i_req_valid[k] = 1'b1;
          bus.i_req_addr[k*32 +: 32] = $urandom;
          bus.i_req_btt[k*23 +: 23] = 23'($urandom);
        end
      end
      bus.i_cmd_tready = ($urandom_range(0, 2) != 0);
      bus.i_sts_tvalid = ($urandom_range(0, 9) < 4);
      bus.i_sts_tlast  = ($urandom_range(0, 4) != 0);
      bus.i_sts_tdata  = {1'($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0,
                          ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, N))};
      @(negedge clk);
      last_rdy = bus.o_req_ready;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
